// File: rtl/sd_spi_master_pkg.sv
// rtl/sd_spi_master_pkg.sv - shared SPI master state type and divider defaults
package sd_spi_master_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE = 2'd0,
    SPI_LOW  = 2'd1,
    SPI_HIGH = 2'd2,
    SPI_DONE = 2'd3
  } spi_state_e;

  localparam int SPI_DIV_FAST_DEF = 1;
  localparam int SPI_DIV_SLOW_DEF = 32;

  // Half-period counter must be able to hold the larger of the two dividers.
  function automatic int spi_cnt_width(input int div_a, input int div_b);
    return $clog2(((div_a > div_b) ? div_a : div_b) + 1);
  endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// rtl/sd_spi_clkgen.sv - SCK half-period counter with rise/fall strobes
module sd_spi_clkgen #(
  parameter int HW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [HW-1:0] half,
  output logic          rise,
  output logic          fall,
  output logic          sck
);

  logic          run_q, run_d;
  logic          sck_q, sck_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] h_q, h_d;
  logic          tick;

  // Strobes lead the clk edge at which SCK actually changes.
  assign tick = run_q && (cnt_q == h_q - HW'(1));
  assign rise = tick && !sck_q;
  assign fall = tick && sck_q;
  assign sck  = sck_q;

  always_comb begin
    run_d = run_q;
    sck_d = sck_q;
    cnt_d = cnt_q;
    h_d   = h_q;
    if (start) begin
      run_d = 1'b1;
      sck_d = 1'b0;
      cnt_d = '0;
      h_d   = half;
    end else if (stop) begin
      run_d = 1'b0;
      sck_d = 1'b0;
      cnt_d = '0;
    end else if (run_q) begin
      if (tick) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      sck_q <= 1'b0;
      cnt_q <= '0;
      h_q   <= HW'(1);
    end else begin
      run_q <= run_d;
      sck_q <= sck_d;
      cnt_q <= cnt_d;
      h_q   <= h_d;
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// rtl/sd_spi_master.sv - byte-level mode-0 SPI master for SD card requests
module sd_spi_master
  import sd_spi_master_pkg::*;
#(
  parameter int DIV_FAST = SPI_DIV_FAST_DEF,
  parameter int DIV_SLOW = SPI_DIV_SLOW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_mode,
  input  logic       cs_en,
  input  logic       sd_tx,
  input  logic       sd_rx,
  input  logic [7:0] d_to_sd,
  output logic [7:0] d_from_sd,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       spi_clk,
  output logic       spi_do,
  input  logic       spi_di,
  output logic       spi_ss
);

  localparam int HW = spi_cnt_width(DIV_FAST, DIV_SLOW);

  spi_state_e state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_full_q, pend_full_d;
  logic [7:0] d_from_q, d_from_d;
  logic       do_q, do_d;
  logic       ss_q, ss_d;
  logic       overrun_q, overrun_d;

  logic          req;
  logic [7:0]    req_data;
  logic          start, stop;
  logic [7:0]    start_data;
  logic [HW-1:0] half;
  logic          rise, fall;

  // sd_tx wins when both request strobes coincide.
  assign req      = sd_tx | sd_rx;
  assign req_data = sd_tx ? d_to_sd : 8'hFF;
  assign half     = slow_mode ? HW'(DIV_SLOW) : HW'(DIV_FAST);

  sd_spi_clkgen #(.HW(HW)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .half  (half),
    .rise  (rise),
    .fall  (fall),
    .sck   (spi_clk)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    d_from_d    = d_from_q;
    do_d        = do_q;
    ss_d        = ss_q;
    overrun_d   = overrun_q;
    start       = 1'b0;
    stop        = 1'b0;
    start_data  = req_data;

    if (state_q != SPI_IDLE && req) begin
      if (pend_full_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d      = req_data;
        pend_full_d = 1'b1;
      end
    end

    case (state_q)
      SPI_IDLE: begin
        if (pend_full_q) begin
          start       = 1'b1;
          start_data  = pend_q;
          pend_full_d = req;
          if (req) pend_d = req_data;
        end else if (req) begin
          start = 1'b1;
        end
      end
      SPI_LOW: begin
        if (rise) begin
          rx_d      = {rx_q[6:0], spi_di};
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = SPI_HIGH;
        end
      end
      SPI_HIGH: begin
        if (fall) begin
          if (bit_cnt_q == 4'd8) begin
            d_from_d = rx_q;
            do_d     = 1'b1;
            state_d  = SPI_DONE;
          end else begin
            tx_d    = {tx_q[6:0], 1'b0};
            do_d    = tx_q[6];
            state_d = SPI_LOW;
          end
        end
      end
      default: begin
        // A request landing here with the buffer full was counted as overrun above.
        state_d = SPI_IDLE;
        if (pend_full_q) begin
          start       = 1'b1;
          start_data  = pend_q;
          pend_full_d = 1'b0;
        end else begin
          stop = 1'b1;
        end
      end
    endcase

    if (start) begin
      tx_d      = start_data;
      do_d      = start_data[7];
      bit_cnt_d = 4'd0;
      state_d   = SPI_LOW;
    end

    if (state_q == SPI_IDLE && !pend_full_q) ss_d = ~cs_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SPI_IDLE;
      tx_q        <= 8'hFF;
      rx_q        <= 8'hFF;
      bit_cnt_q   <= 4'd0;
      pend_q      <= 8'h00;
      pend_full_q <= 1'b0;
      d_from_q    <= 8'hFF;
      do_q        <= 1'b1;
      ss_q        <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      d_from_q    <= d_from_d;
      do_q        <= do_d;
      ss_q        <= ss_d;
      overrun_q   <= overrun_d;
    end
  end

  assign d_from_sd = d_from_q;
  assign busy      = (state_q != SPI_IDLE) || pend_full_q;
  assign done      = (state_q == SPI_DONE);
  assign overrun   = overrun_q;
  assign spi_do    = do_q;
  assign spi_ss    = ss_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// tb/tb_sd_spi_master.sv - scoreboard bench for sd_spi_master
module tb_sd_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_mode = 1'b0;
  logic       cs_en = 1'b0;
  logic       sd_tx = 1'b0;
  logic       sd_rx = 1'b0;
  logic [7:0] d_to_sd = 8'h00;
  logic [7:0] d_from_sd;
  logic       busy, done, overrun, spi_clk, spi_do, spi_di, spi_ss;
  logic       loop_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;
  int done_cnt = 0;
  int nbits = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic       sck_prev = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  assign spi_di = loop_en ? spi_do : 1'b0;

  sd_spi_master #(.DIV_FAST(1), .DIV_SLOW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .slow_mode (slow_mode),
    .cs_en     (cs_en),
    .sd_tx     (sd_tx),
    .sd_rx     (sd_rx),
    .d_to_sd   (d_to_sd),
    .d_from_sd (d_from_sd),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .spi_clk   (spi_clk),
    .spi_do    (spi_do),
    .spi_di    (spi_di),
    .spi_ss    (spi_ss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: collect MOSI on SCK rises, score each done against the queues.
  always @(negedge clk) begin
    if (reset) begin
      nbits = 0;
    end else begin
      if (spi_clk && !sck_prev) begin
        mosi_sr = {mosi_sr[6:0], spi_do};
        nbits = nbits + 1;
      end
      if (done) begin
        prev_done_cyc = done_cyc;
        done_cyc = cyc;
        done_cnt = done_cnt + 1;
        if (exp_tx_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("bit_count", nbits, 8);
          chk("mosi_byte", mosi_sr, exp_tx_q.pop_front());
          chk("d_from_sd", d_from_sd, exp_rx_q.pop_front());
        end
        nbits = 0;
      end
    end
    sck_prev = spi_clk;
  end

  task automatic push_exp(input logic [7:0] payload);
    exp_tx_q.push_back(payload);
    exp_rx_q.push_back(loop_en ? payload : 8'h00);
  endtask

  task automatic send(input logic tx, input logic rx, input logic [7:0] d);
    @(negedge clk);
    sd_tx = tx;
    sd_rx = rx;
    d_to_sd = d;
    req_cyc = cyc;
    push_exp(tx ? d : 8'hFF);
    @(posedge clk);
    #1;
    sd_tx = 1'b0;
    sd_rx = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int dc;
    logic ss_held;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_clk", spi_clk, 1'b0);
    chk("rst_spi_do", spi_do, 1'b1);
    chk("rst_spi_ss", spi_ss, 1'b1);
    chk("rst_d_from_sd", d_from_sd, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cs_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ss_select", spi_ss, 1'b0);

    send(1'b1, 1'b0, 8'hA5);
    chk("busy_after_req", busy, 1'b1);
    wait_idle(100);
    chk("latency_fast", done_cyc - req_cyc, 17);

    loop_en = 1'b1;
    send(1'b0, 1'b1, 8'h00);
    wait_idle(100);
    send(1'b1, 1'b0, 8'h3C);
    wait_idle(100);

    slow_mode = 1'b1;
    send(1'b1, 1'b0, 8'h96);
    repeat (10) @(posedge clk);
    #1;
    slow_mode = 1'b0;
    wait_idle(200);
    chk("latency_slow", done_cyc - req_cyc, 65);
    send(1'b1, 1'b0, 8'h69);
    repeat (3) @(posedge clk);
    #1;
    slow_mode = 1'b1;
    wait_idle(200);
    chk("latency_fast_toggle", done_cyc - req_cyc, 17);
    slow_mode = 1'b0;

    chk("overrun_clear", overrun, 1'b0);
    dc = done_cnt;
    @(negedge clk);
    sd_tx = 1'b1;
    d_to_sd = 8'h11;
    push_exp(8'h11);
    @(negedge clk);
    d_to_sd = 8'h22;
    push_exp(8'h22);
    @(negedge clk);
    d_to_sd = 8'h33;
    @(negedge clk);
    sd_tx = 1'b0;
    wait_idle(200);
    chk("buffer_done_count", done_cnt - dc, 2);
    chk("back_to_back_gap", done_cyc - prev_done_cyc, 17);
    chk("overrun_set", overrun, 1'b1);

    send(1'b1, 1'b1, 8'h5A);
    wait_idle(100);

    send(1'b1, 1'b0, 8'hC3);
    repeat (4) @(posedge clk);
    #1;
    cs_en = 1'b0;
    ss_held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      if (spi_ss !== 1'b0) ss_held = 1'b0;
    end
    chk("ss_held_busy", ss_held, 1'b1);
    @(posedge clk);
    #1;
    chk("ss_release_idle", spi_ss, 1'b1);

    send(1'b1, 1'b0, 8'hE7);
    for (int i = 0; i < 40; i++) begin
      if (nbits >= 3) break;
      @(negedge clk);
    end
    chk("reached_bit3", nbits >= 3, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    exp_tx_q.delete();
    exp_rx_q.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    chk("mid_rst_spi_clk", spi_clk, 1'b0);
    chk("mid_rst_spi_do", spi_do, 1'b1);
    chk("mid_rst_spi_ss", spi_ss, 1'b1);
    chk("mid_rst_d_from_sd", d_from_sd, 8'hFF);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - dc, 0);
    chk("scoreboard_empty", exp_tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
